// File: rtl/jtframe_rq_arbiter.sv
// jtframe_rq_arbiter
// Shares one single-port SDRAM controller among several request slots.
// One slot is granted at a time, and its command is forwarded to the controller.
// Read data comes back to every slot on a shared bus. A one-hot slot_we strobe
// names the slot that owns the current slot_din_ok pulse.
//
// Parameters:
//   SLOTS  number of request slots (2..8)
//   AW     SDRAM word address width
//
// Ports:
//   clk, rst_n          system clock; asynchronous active-low reset
//   slot_req            per-slot request level, held until served
//   slot_rnw            per-slot direction (1=read, 0=write)
//   slot_addr           per-slot word address, slot i at [i*AW +: AW]
//   slot_wrdata         per-slot write word, slot i at [i*16 +: 16]
//   slot_we             one-hot owner of the current completion pulse
//   slot_din            shared read data bus, holds the last read value
//   slot_din_ok         one-cycle completion strobe
//   ctl_req/rnw/addr/wdata  command towards the SDRAM controller
//   ctl_ack             controller accepted the command
//   ctl_rdy, ctl_dout   read data valid / write done, with read data
//
// Configuration macro:
//   JTFRAME_ARB_FIXPRIO_EN  fixed priority (lowest index wins) instead of
//                           round-robin. The rotation pointer is held at 0.

module jtframe_rq_arbiter #(
   parameter int SLOTS = 4,
   parameter int AW    = 22
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SLOTS-1:0]    slot_req,
   input  logic [SLOTS-1:0]    slot_rnw,
   input  logic [SLOTS*AW-1:0] slot_addr,
   input  logic [SLOTS*16-1:0] slot_wrdata,
   output logic [SLOTS-1:0]    slot_we,
   output logic [31:0]         slot_din,
   output logic                slot_din_ok,
   output logic                ctl_req,
   output logic                ctl_rnw,
   output logic [AW-1:0]       ctl_addr,
   output logic [15:0]         ctl_wdata,
   input  logic                ctl_ack,
   input  logic                ctl_rdy,
   input  logic [31:0]         ctl_dout
);

   localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gnt;
   logic [PW-1:0]   winner;
   logic            found;
   logic            any_req;
   logic            start;
   logic            acked;
   logic            finish;
   logic            sel_rnw;
   logic [AW-1:0]   sel_addr;
   logic [15:0]     sel_wdata;
   int              cand;

   // Round-robin search: walk the slots starting at ptr, wrapping past the
   // last slot, and take the first one requesting. With fixed priority ptr
   // is always 0, so the same search yields the lowest requesting index.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      cand   = 0;
      for (int i = 0; i < SLOTS; i++) begin
         cand = int'(ptr) + i;
         if (cand >= SLOTS) cand = cand - SLOTS;
         if (!found && slot_req[PW'(cand)]) begin
            winner = PW'(cand);
            found  = 1'b1;
         end
      end
   end

   // Multiplex the winning slot's command fields, ready to be latched.
   always_comb begin
      sel_rnw   = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (winner == PW'(i)) begin
            sel_rnw   = slot_rnw[i];
            sel_addr  = slot_addr[i*AW +: AW];
            sel_wdata = slot_wrdata[i*16 +: 16];
         end
      end
   end

   // Handshake events. A completion can come either from the merged case
   // (ack and rdy together while issuing) or from rdy while waiting. ack/rdy
   // seen in any other state are ignored.
   always_comb begin
      any_req = |slot_req;
      start   = (state == ST_IDLE) && any_req;
      acked   = (state == ST_ISSUE) && ctl_ack;
      finish  = ((state == ST_ISSUE) && ctl_ack && ctl_rdy) ||
                ((state == ST_WAIT) && ctl_rdy);
   end

   // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
         ST_ISSUE: if (ctl_ack) state_nxt = ctl_rdy ? ST_DONE : ST_WAIT;
         ST_WAIT:  if (ctl_rdy) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register. Reset drops straight back to IDLE, even mid-transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Command and response registers. The command fields are latched once, when
   // the grant is made, so they stay stable while the controller stalls. A
   // completion arms slot_din_ok/slot_we for the single DONE cycle. The rotation
   // pointer then moves past the slot just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         gnt         <= '0;
         ctl_req     <= 1'b0;
         ctl_rnw     <= 1'b0;
         ctl_addr    <= '0;
         ctl_wdata   <= '0;
         slot_we     <= '0;
         slot_din    <= '0;
         slot_din_ok <= 1'b0;
      end else begin
         slot_din_ok <= 1'b0;
         slot_we     <= '0;
         if (start) begin
            gnt       <= winner;
            ctl_req   <= 1'b1;
            ctl_rnw   <= sel_rnw;
            ctl_addr  <= sel_addr;
            ctl_wdata <= sel_wdata;
         end
         if (acked) ctl_req <= 1'b0;
         if (finish) begin
            if (ctl_rnw) slot_din <= ctl_dout;
            slot_din_ok <= 1'b1;
            slot_we     <= {{(SLOTS-1){1'b0}}, 1'b1} << gnt;
         end
         if (state == ST_DONE) begin
`ifdef JTFRAME_ARB_FIXPRIO_EN
            ptr <= '0;
`else
            ptr <= (gnt == PW'(SLOTS-1)) ? '0 : gnt + 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jtframe_rq_arbiter.sv
// tb_jtframe_rq_arbiter
// Directed bench for jtframe_rq_arbiter (default round-robin build).
// The bench drives the slot side and plays the SDRAM controller. Expected
// grants, command fields and read data are worked out by hand for each vector.

module tb_jtframe_rq_arbiter;

   localparam int SLOTS = 4;
   localparam int AW    = 22;

   logic                clk;
   logic                rst_n;
   logic [SLOTS-1:0]    slot_req;
   logic [SLOTS-1:0]    slot_rnw;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS*16-1:0] slot_wrdata;
   logic [SLOTS-1:0]    slot_we;
   logic [31:0]         slot_din;
   logic                slot_din_ok;
   logic                ctl_req;
   logic                ctl_rnw;
   logic [AW-1:0]       ctl_addr;
   logic [15:0]         ctl_wdata;
   logic                ctl_ack;
   logic                ctl_rdy;
   logic [31:0]         ctl_dout;

   int            checkCount;
   int            failCount;
   logic [31:0]   expDin;
   logic          rnwArr  [SLOTS];
   logic [AW-1:0] addrArr [SLOTS];
   logic [15:0]   wdArr   [SLOTS];

   jtframe_rq_arbiter #(.SLOTS(SLOTS), .AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .slot_req    (slot_req),
      .slot_rnw    (slot_rnw),
      .slot_addr   (slot_addr),
      .slot_wrdata (slot_wrdata),
      .slot_we     (slot_we),
      .slot_din    (slot_din),
      .slot_din_ok (slot_din_ok),
      .ctl_req     (ctl_req),
      .ctl_rnw     (ctl_rnw),
      .ctl_addr    (ctl_addr),
      .ctl_wdata   (ctl_wdata),
      .ctl_ack     (ctl_ack),
      .ctl_rdy     (ctl_rdy),
      .ctl_dout    (ctl_dout)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic setSlot(input int i, input logic rnw, input logic [AW-1:0] addr, input logic [15:0] wd);
      rnwArr[i]  = rnw;
      addrArr[i] = addr;
      wdArr[i]   = wd;
      slot_rnw[i]              = rnw;
      slot_addr[i*AW +: AW]    = addr;
      slot_wrdata[i*16 +: 16]  = wd;
   endtask

   // One full transaction, starting in IDLE with requests already raised.
   // expSlot is the slot that must win. ackDelay is the number of stalled ISSUE
   // cycles. rdyDelay is the number of WAIT cycles (0 means ack and rdy arrive
   // together). perturb wiggles the slot inputs while the command is stalled.
   task automatic applyStimulus(input int expSlot, input int ackDelay, input int rdyDelay,
                                input logic [31:0] dout, input bit perturb);
      logic          eRnw;
      logic [AW-1:0] eAddr;
      logic [15:0]   eWd;
      logic [3:0]    savedReq;
      logic [3:0]    othersMask;
      eRnw       = rnwArr[expSlot];
      eAddr      = addrArr[expSlot];
      eWd        = wdArr[expSlot];
      savedReq   = slot_req;
      othersMask = ~(4'b0001 << expSlot);
      tick();
      checkOutput("ctl_req_set", ctl_req, 1);
      checkOutput("ctl_rnw", ctl_rnw, eRnw);
      checkOutput("ctl_addr", ctl_addr, eAddr);
      checkOutput("ctl_wdata", ctl_wdata, eWd);
      for (int k = 0; k < ackDelay; k++) begin
         if (perturb) begin
            slot_req                    = slot_req ^ (4'(k + 1) & othersMask);
            slot_addr[expSlot*AW +: AW] = eAddr ^ AW'(k + 1);
            slot_wrdata[expSlot*16 +: 16] = eWd ^ 16'(k + 7);
            slot_rnw[expSlot]           = ~slot_rnw[expSlot];
         end
         tick();
         checkOutput("hold_req", ctl_req, 1);
         checkOutput("hold_addr", ctl_addr, eAddr);
         if (perturb) begin
            checkOutput("hold_rnw", ctl_rnw, eRnw);
            checkOutput("hold_wdata", ctl_wdata, eWd);
         end
      end
      if (perturb) begin
         slot_req                      = savedReq;
         slot_addr[expSlot*AW +: AW]   = eAddr;
         slot_wrdata[expSlot*16 +: 16] = eWd;
         slot_rnw[expSlot]             = eRnw;
      end
      ctl_ack = 1'b1;
      if (rdyDelay == 0) begin
         ctl_rdy  = 1'b1;
         ctl_dout = dout;
      end else begin
         ctl_dout = ~dout;
      end
      tick();
      ctl_ack  = 1'b0;
      ctl_rdy  = 1'b0;
      ctl_dout = ~dout;
      if (rdyDelay > 0) begin
         checkOutput("ctl_req_drop", ctl_req, 0);
         checkOutput("no_early_ok", slot_din_ok, 0);
         repeat (rdyDelay - 1) tick();
         ctl_rdy  = 1'b1;
         ctl_dout = dout;
         tick();
         ctl_rdy  = 1'b0;
         ctl_dout = ~dout;
      end
      if (eRnw) expDin = dout;
      checkOutput("done_ctl_req", ctl_req, 0);
      checkOutput("din_ok", slot_din_ok, 1);
      checkOutput("slot_we", slot_we, 4'b0001 << expSlot);
      checkOutput("slot_din", slot_din, expDin);
      slot_req[expSlot] = 1'b0;
      tick();
      checkOutput("din_ok_pulse", slot_din_ok, 0);
      checkOutput("slot_we_clr", slot_we, 0);
      checkOutput("slot_din_hold", slot_din, expDin);
   endtask

   initial begin
      checkCount  = 0;
      failCount   = 0;
      expDin      = '0;
      rst_n       = 1'b0;
      slot_req    = '0;
      slot_rnw    = '0;
      slot_addr   = '0;
      slot_wrdata = '0;
      ctl_ack     = 1'b0;
      ctl_rdy     = 1'b0;
      ctl_dout    = '0;
      for (int i = 0; i < SLOTS; i++) setSlot(i, 1'b0, '0, '0);

      // Reset state
      tick();
      tick();
      checkOutput("rst_ctl_req", ctl_req, 0);
      checkOutput("rst_ctl_rnw", ctl_rnw, 0);
      checkOutput("rst_ctl_addr", ctl_addr, 0);
      checkOutput("rst_ctl_wdata", ctl_wdata, 0);
      checkOutput("rst_slot_we", slot_we, 0);
      checkOutput("rst_slot_din", slot_din, 0);
      checkOutput("rst_din_ok", slot_din_ok, 0);
      rst_n = 1'b1;
      tick();

      // Read from slot 2, ack one cycle late, data three WAIT cycles later
      $display("[TB] read slot 2");
      setSlot(2, 1'b1, 22'h12345, 16'h0000);
      slot_req[2] = 1'b1;
      applyStimulus(2, 1, 3, 32'hDEADBEEF, 1'b0);

      // Write from slot 1; slot_din must keep the previous read value
      $display("[TB] write slot 1");
      setSlot(1, 1'b0, 22'h00100, 16'hA55A);
      slot_req[1] = 1'b1;
      applyStimulus(1, 0, 2, 32'h11111111, 1'b0);

      // Merged ack and rdy from slot 0
      $display("[TB] merged handshake slot 0");
      setSlot(0, 1'b1, 22'h2ABCD, 16'h1234);
      slot_req[0] = 1'b1;
      applyStimulus(0, 0, 0, 32'hCAFEF00D, 1'b0);

      // Controller stalls 20 cycles while slot inputs wiggle
      $display("[TB] stall slot 3");
      setSlot(3, 1'b1, 22'h3AAAA, 16'h5A5A);
      slot_req[3] = 1'b1;
      applyStimulus(3, 20, 1, 32'h0BADC0DE, 1'b1);

      // Fairness: every slot requests continuously, pointer starts at 0
      $display("[TB] fairness");
      for (int i = 0; i < SLOTS; i++) setSlot(i, 1'b1, AW'(22'h10000 + i), 16'(i));
      slot_req = 4'hF;
      for (int n = 0; n < 6; n++) begin
         applyStimulus(n % 4, 0, 1, 32'hC0DE0000 + 32'(n), 1'b0);
         slot_req[n % 4] = 1'b1;
      end
      slot_req = '0;
      tick();
      checkOutput("idle_no_req", ctl_req, 0);

      // Reset while waiting for data
      $display("[TB] reset in WAIT");
      setSlot(3, 1'b1, 22'h0F0F0, 16'h0000);
      slot_req[3] = 1'b1;
      tick();
      checkOutput("rw_issue", ctl_req, 1);
      ctl_ack = 1'b1;
      tick();
      ctl_ack = 1'b0;
      slot_req = '0;
      rst_n = 1'b0;
      #1;
      checkOutput("rw_ctl_req", ctl_req, 0);
      checkOutput("rw_slot_we", slot_we, 0);
      checkOutput("rw_slot_din", slot_din, 0);
      checkOutput("rw_din_ok", slot_din_ok, 0);
      tick();
      rst_n  = 1'b1;
      expDin = '0;
      ctl_rdy  = 1'b1;
      ctl_dout = 32'hFFFF0000;
      tick();
      ctl_rdy = 1'b0;
      checkOutput("late_rdy_ok", slot_din_ok, 0);
      checkOutput("late_rdy_we", slot_we, 0);
      checkOutput("late_rdy_din", slot_din, 0);
      checkOutput("late_rdy_req", ctl_req, 0);

      // After reset the pointer is back at 0, so slot 1 beats slot 3
      setSlot(1, 1'b1, 22'h01111, 16'h0000);
      setSlot(3, 1'b0, 22'h03333, 16'hBEEF);
      slot_req = 4'b1010;
      applyStimulus(1, 0, 1, 32'h76543210, 1'b0);
      applyStimulus(3, 1, 1, 32'h99999999, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
